// File: rtl/fwht_frame_pkg.sv
// fwht_frame_pkg
// Definitions shared by the FWHT frame controller and its counter.
//   - FSM state encoding (plain localparams so older tools and testbenches
//     can match on the raw values)
//   - bit positions of the sticky error flags within the error vector
//   - sticky_next(): update rule for the sticky error vector
package fwht_frame_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD    = 3'd1;
  localparam logic [STATE_W-1:0] ST_PAD     = 3'd2;
  localparam logic [STATE_W-1:0] ST_DISCARD = 3'd3;
  localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd4;
  localparam logic [STATE_W-1:0] ST_UNLOAD  = 3'd5;

  localparam int ERR_SHORT_BIT   = 0;
  localparam int ERR_LONG_BIT    = 1;
  localparam int ERR_OVERRUN_BIT = 2;
  localparam int ERR_BITS        = 3;

  // A new error event wins over a clear request in the same cycle, so an
  // event is never hidden by a clear that happens to land on the same edge.
  function automatic logic [ERR_BITS-1:0] sticky_next(
    input logic [ERR_BITS-1:0] cur,
    input logic [ERR_BITS-1:0] set,
    input logic                clr
  );
    return set | (clr ? '0 : cur);
  endfunction

endpackage

// File: rtl/fwht_frame_cnt.sv
// fwht_frame_cnt
// L_WIDTH-bit up-counter used for the input slot and output beat counts.
// Ports:
//   ACLK      clock, rising edge
//   ARESET    synchronous active-high reset, clears the count
//   clr       synchronous clear (has priority over en)
//   en        advance the count by one
//   terminal  high while the count is all ones (last slot of a frame)
module fwht_frame_cnt
  import fwht_frame_pkg::*;
#(
  parameter int L_WIDTH = 12
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  logic [L_WIDTH-1:0] count;

  always_ff @(posedge ACLK) begin
    if (ARESET || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // The end of a frame is detected by the all-ones compare, not by a
  // wrap back to zero.
  assign terminal = &count;

endmodule

// File: rtl/fwht_frame_ctrl.sv
// fwht_frame_ctrl
// Frames an upstream sample stream into fixed N = 2^L_WIDTH sample blocks
// for a non-stalling FWHT pipeline, then forwards the pipeline output
// downstream with frame boundaries and sticky error reporting.
// Ports:
//   ACLK, ARESET                clock / synchronous active-high reset
//   enable                      allows a new frame to start (IDLE only)
//   err_clr                     clears the sticky error flags
//   s_axis_*                    upstream frame stream (tdata/tvalid/tready/tlast)
//   f_tdata, f_tvalid, f_tready feed into the transform pipeline
//   f_out_*                     transform pipeline output (data/valid/index)
//   m_axis_*                    downstream stream, tuser = sequency index
//   busy                        high whenever not IDLE
//   frames_done                 completed frame count, wraps at 16 bits
//   err_short/long/overrun      sticky error flags
module fwht_frame_ctrl
  import fwht_frame_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int L_WIDTH = 12
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               enable,
  input  logic               err_clr,
  input  logic [WIDTH-1:0]   s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [WIDTH-1:0]   f_tdata,
  output logic               f_tvalid,
  input  logic               f_tready,
  input  logic [WIDTH-1:0]   f_out_tdata,
  input  logic               f_out_tvalid,
  input  logic [L_WIDTH-1:0] f_out_index,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [L_WIDTH-1:0] m_axis_tuser,
  output logic               busy,
  output logic [15:0]        frames_done,
  output logic               err_short,
  output logic               err_long,
  output logic               err_overrun
);

  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  state_nxt;
  logic                in_clr;
  logic                in_en;
  logic                in_last;
  logic                out_clr;
  logic                out_last;
  logic                out_beat;
  logic                frame_done;
  logic                tlast_seen;
  logic [ERR_BITS-1:0] err_set;
  logic [ERR_BITS-1:0] err_q;

  fwht_frame_cnt #(.L_WIDTH(L_WIDTH)) u_in_cnt (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .clr      (in_clr),
    .en       (in_en),
    .terminal (in_last)
  );

  fwht_frame_cnt #(.L_WIDTH(L_WIDTH)) u_out_cnt (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .clr      (out_clr),
    .en       (out_beat),
    .terminal (out_last)
  );

  // tready is high in every state that evaluates tlast, so a valid tlast
  // there is always an accepted one.
  assign tlast_seen = s_axis_tvalid & s_axis_tlast;

  // The first pipeline output beat arrives while still in DRAIN, so beats
  // are counted in both DRAIN and UNLOAD.
  assign out_beat   = f_out_tvalid & ((state == ST_DRAIN) | (state == ST_UNLOAD));
  assign frame_done = out_beat & out_last;

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    f_tvalid      = 1'b0;
    f_tdata       = '0;
    in_clr        = 1'b0;
    in_en         = 1'b0;
    out_clr       = 1'b0;
    err_set       = '0;
    case (state)
      ST_IDLE: begin
        in_clr  = 1'b1;
        out_clr = 1'b1;
        // Waiting for f_tready also lets the pipeline flush itself after a
        // reset that hit in the middle of a frame.
        if (enable && s_axis_tvalid && f_tready) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The pipeline cannot stall: every cycle is a slot, and an upstream
        // gap becomes a zero sample.
        s_axis_tready = 1'b1;
        f_tvalid      = 1'b1;
        f_tdata       = s_axis_tvalid ? s_axis_tdata : '0;
        in_en         = 1'b1;
        if (in_last) begin
          if (tlast_seen) begin
            state_nxt = ST_DRAIN;
          end else begin
            err_set[ERR_LONG_BIT] = 1'b1;
            state_nxt             = ST_DISCARD;
          end
        end else if (tlast_seen) begin
          err_set[ERR_SHORT_BIT] = 1'b1;
          state_nxt              = ST_PAD;
        end
      end
      ST_PAD: begin
        f_tvalid = 1'b1;
        in_en    = 1'b1;
        if (in_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DISCARD: begin
        s_axis_tready = 1'b1;
        if (tlast_seen) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (f_out_tvalid) begin
          state_nxt = out_last ? ST_IDLE : ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        if (frame_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Output beats cannot be held back; a refused beat is lost and flagged.
    err_set[ERR_OVERRUN_BIT] = m_axis_tvalid & ~m_axis_tready;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= ST_IDLE;
      frames_done   <= '0;
      err_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state         <= state_nxt;
      err_q         <= sticky_next(err_q, err_set, err_clr);
      m_axis_tdata  <= f_out_tdata;
      m_axis_tvalid <= f_out_tvalid;
      m_axis_tuser  <= f_out_index;
      m_axis_tlast  <= frame_done;
      if (frame_done) begin
        frames_done <= frames_done + 16'd1;
      end
    end
  end

  assign busy        = (state != ST_IDLE);
  assign err_short   = err_q[ERR_SHORT_BIT];
  assign err_long    = err_q[ERR_LONG_BIT];
  assign err_overrun = err_q[ERR_OVERRUN_BIT];

endmodule

// File: tb/tb_fwht_frame_ctrl.sv
// tb_fwht_frame_ctrl
// Directed bench for fwht_frame_ctrl with N = 8. The bench plays both the
// upstream source and the transform pipeline: it records every slot fed
// into the pipeline and drives hand-chosen pipeline output beats.
module tb_fwht_frame_ctrl;

  localparam int WIDTH   = 32;
  localparam int L_WIDTH = 3;
  localparam int N       = 8;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               enable;
  logic               err_clr;
  logic [WIDTH-1:0]   s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic               s_axis_tlast;
  logic [WIDTH-1:0]   f_tdata;
  logic               f_tvalid;
  logic               f_tready;
  logic [WIDTH-1:0]   f_out_tdata;
  logic               f_out_tvalid;
  logic [L_WIDTH-1:0] f_out_index;
  logic [WIDTH-1:0]   m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               m_axis_tlast;
  logic [L_WIDTH-1:0] m_axis_tuser;
  logic               busy;
  logic [15:0]        frames_done;
  logic               err_short;
  logic               err_long;
  logic               err_overrun;

  int tests    = 0;
  int failures = 0;

  logic [WIDTH-1:0] fed[$];
  logic [WIDTH-1:0] vecData[16];
  logic [15:0]      vecValid;
  logic [15:0]      vecLast;
  logic [WIDTH-1:0] expFed[N];

  always #5 ACLK = ~ACLK;

  fwht_frame_ctrl #(.WIDTH(WIDTH), .L_WIDTH(L_WIDTH)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .enable        (enable),
    .err_clr       (err_clr),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .f_tdata       (f_tdata),
    .f_tvalid      (f_tvalid),
    .f_tready      (f_tready),
    .f_out_tdata   (f_out_tdata),
    .f_out_tvalid  (f_out_tvalid),
    .f_out_index   (f_out_index),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .frames_done   (frames_done),
    .err_short     (err_short),
    .err_long      (err_long),
    .err_overrun   (err_overrun)
  );

  // Record each slot the pipeline is handed, sampled mid-cycle.
  always @(negedge ACLK) begin
    if (f_tvalid === 1'b1) begin
      fed.push_back(f_tdata);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Present one upstream slot and let one clock edge consume it.
  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                               input logic last);
    s_axis_tvalid = valid;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    tick();
  endtask

  // Start a frame from IDLE and push len upstream slots from the vec tables.
  task automatic loadFrame(input int len);
    fed.delete();
    enable        = 1'b1;
    s_axis_tvalid = vecValid[0];
    s_axis_tdata  = vecData[0];
    s_axis_tlast  = vecLast[0];
    tick();
    checkOutput("load_entered", 32'({busy, s_axis_tready, f_tvalid}), 32'b111);
    for (int i = 0; i < len; i++) begin
      applyStimulus(vecValid[i], vecData[i], vecLast[i]);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    enable        = 1'b0;
  endtask

  task automatic checkFed();
    checkOutput("fed_count", 32'(fed.size()), N);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("fed_slot%0d", i),
                  (i < fed.size()) ? fed[i] : 32'hxxxx_xxxx, expFed[i]);
    end
  endtask

  // Wait for DRAIN, then act as the pipeline and emit N output beats.
  // Downstream refuses the beat with index overrunBeat (-1 for none).
  task automatic unloadFrame(input logic [31:0] base, input int overrunBeat);
    int waited = 0;
    while (!(busy && !s_axis_tready && !f_tvalid) && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("reach_drain", 32'(waited < 20), 32'd1);
    for (int k = 0; k < N; k++) begin
      f_out_tvalid = 1'b1;
      f_out_tdata  = base + 32'(k);
      f_out_index  = L_WIDTH'(k);
      tick();
      checkOutput($sformatf("m_tvalid_b%0d", k), 32'(m_axis_tvalid), 32'd1);
      checkOutput($sformatf("m_tdata_b%0d", k), m_axis_tdata, base + 32'(k));
      checkOutput($sformatf("m_tuser_b%0d", k), 32'(m_axis_tuser), 32'(k));
      checkOutput($sformatf("m_tlast_b%0d", k), 32'(m_axis_tlast), 32'(k == N - 1));
      m_axis_tready = (k == overrunBeat) ? 1'b0 : 1'b1;
    end
    f_out_tvalid  = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    checkOutput("m_tvalid_drop", 32'(m_axis_tvalid), 32'd0);
    checkOutput("idle_after_unload", 32'(busy), 32'd0);
  endtask

  task automatic pulseErrClr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    ARESET        = 1'b1;
    enable        = 1'b0;
    err_clr       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    f_tready      = 1'b1;
    f_out_tdata   = '0;
    f_out_tvalid  = 1'b0;
    f_out_index   = '0;
    m_axis_tready = 1'b1;
    vecValid      = '1;
    vecLast       = '0;
    for (int i = 0; i < 16; i++) vecData[i] = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready_valid", 32'({s_axis_tready, f_tvalid}), 32'd0);
    checkOutput("rst_m_axis", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
    checkOutput("rst_m_tdata", m_axis_tdata, 32'd0);
    checkOutput("rst_frames", 32'(frames_done), 32'd0);
    checkOutput("rst_errs", 32'({err_short, err_long, err_overrun}), 32'd0);
    ARESET = 1'b0;
    tick();

    // Full 8-sample frame
    $display("[TB] frame 1: nominal 8 samples");
    for (int i = 0; i < N; i++) begin
      vecData[i] = 32'(i + 1);
      expFed[i]  = 32'(i + 1);
    end
    vecLast = 16'h0080;
    loadFrame(8);
    unloadFrame(32'hA000_0010, -1);
    checkFed();
    checkOutput("f1_frames", 32'(frames_done), 32'd1);
    checkOutput("f1_errs", 32'({err_short, err_long, err_overrun}), 32'd0);

    // Short frame: tlast on the 5th sample, slots 5..7 padded with zeros
    $display("[TB] frame 2: short frame");
    for (int i = 0; i < N; i++) begin
      vecData[i] = 32'h11 + 32'(i);
      expFed[i]  = (i < 5) ? 32'h11 + 32'(i) : 32'd0;
    end
    vecLast = 16'h0010;
    loadFrame(5);
    checkOutput("f2_err_short", 32'(err_short), 32'd1);
    checkOutput("f2_pad_state", 32'({busy, s_axis_tready, f_tvalid}), 32'b101);
    unloadFrame(32'hA000_0020, -1);
    checkFed();
    checkOutput("f2_frames", 32'(frames_done), 32'd2);
    pulseErrClr();
    checkOutput("f2_err_clr", 32'(err_short), 32'd0);

    // Long frame: 10 samples, the last two are dropped
    $display("[TB] frame 3: long frame");
    for (int i = 0; i < 10; i++) vecData[i] = 32'h21 + 32'(i);
    for (int i = 0; i < N; i++) expFed[i] = 32'h21 + 32'(i);
    vecLast = 16'h0200;
    loadFrame(10);
    checkOutput("f3_err_long", 32'(err_long), 32'd1);
    checkOutput("f3_err_short", 32'(err_short), 32'd0);
    unloadFrame(32'hA000_0030, -1);
    checkFed();
    checkOutput("f3_frames", 32'(frames_done), 32'd3);
    pulseErrClr();
    checkOutput("f3_err_clr", 32'(err_long), 32'd0);

    // Downstream stall on output beat 3
    $display("[TB] frame 4: downstream overrun");
    for (int i = 0; i < N; i++) begin
      vecData[i] = 32'h31 + 32'(i);
      expFed[i]  = 32'h31 + 32'(i);
    end
    vecLast = 16'h0080;
    loadFrame(8);
    unloadFrame(32'hA000_0040, 3);
    checkFed();
    checkOutput("f4_err_overrun", 32'(err_overrun), 32'd1);
    checkOutput("f4_frames", 32'(frames_done), 32'd4);
    pulseErrClr();
    checkOutput("f4_err_clr", 32'(err_overrun), 32'd0);

    // Reset in the middle of LOAD at in_cnt = 4
    $display("[TB] frame 5: reset mid-load");
    for (int i = 0; i < N; i++) vecData[i] = 32'h41 + 32'(i);
    vecLast = 16'h0000;
    loadFrame(4);
    ARESET = 1'b1;
    tick();
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_ready_valid", 32'({s_axis_tready, f_tvalid}), 32'd0);
    checkOutput("mrst_m_axis", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd0);
    checkOutput("mrst_m_tdata", m_axis_tdata, 32'd0);
    checkOutput("mrst_frames", 32'(frames_done), 32'd0);
    ARESET        = 1'b0;
    f_tready      = 1'b0;
    enable        = 1'b1;
    s_axis_tvalid = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("mrst_hold_idle", 32'(busy), 32'd0);
    f_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      vecData[i] = 32'h51 + 32'(i);
      expFed[i]  = 32'h51 + 32'(i);
    end
    vecLast = 16'h0080;
    loadFrame(8);
    unloadFrame(32'hA000_0050, -1);
    checkFed();
    checkOutput("f5_frames", 32'(frames_done), 32'd1);
    checkOutput("f5_errs", 32'({err_short, err_long, err_overrun}), 32'd0);

    // Upstream gap at slot 2 becomes a zero sample
    $display("[TB] frame 6: upstream gap at slot 2");
    for (int i = 0; i < N; i++) begin
      vecData[i] = (i == 2) ? 32'hDEAD : 32'h61 + 32'(i);
      expFed[i]  = (i == 2) ? 32'd0 : 32'h61 + 32'(i);
    end
    vecValid = 16'hFFFB;
    vecLast  = 16'h0080;
    loadFrame(8);
    unloadFrame(32'hA000_0060, -1);
    checkFed();
    checkOutput("f6_frames", 32'(frames_done), 32'd2);
    checkOutput("f6_errs", 32'({err_short, err_long, err_overrun}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fwht_frame_ctrl.md
FWHT_FRAME_CTRL -- requirements
Module: fwht_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, sample width in bits.
REQ-002 Parameter L_WIDTH, default 12, log2 of frame length; N = 2^L_WIDTH samples per frame.
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESET  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  permits starting a new frame; sampled only in IDLE.
REQ-006 err_clr  input  1  clears all sticky error flags.
REQ-007 s_axis_tdata/tvalid/tready/tlast  in/in/out/in  WIDTH/1/1/1  upstream frame stream.
REQ-008 f_tdata/f_tvalid  output  WIDTH/1  feed to transform pipeline input.
REQ-009 f_tready  input  1  transform pipeline input ready.
REQ-010 f_out_tdata/f_out_tvalid/f_out_index  input  WIDTH/1/L_WIDTH  transform pipeline output.
REQ-011 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  WIDTH/1/1/1/L_WIDTH  downstream stream; tuser carries sequency index.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 frames_done  output  16  completed-frame count, wraps 0xFFFF->0.
REQ-014 err_short, err_long, err_overrun  output  1 each  sticky error flags.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, PAD, DISCARD, DRAIN, UNLOAD.
REQ-016 IDLE: s_axis_tready=0, f_tvalid=0; go to LOAD when enable & s_axis_tvalid & f_tready.
REQ-017 LOAD: f_tvalid=1 every cycle; in_cnt increments every cycle from 0; s_axis_tready=1.
REQ-018 LOAD: f_tdata=s_axis_tdata when s_axis_tvalid, else zero; an upstream gap consumes one slot as a zero sample (pipeline cannot stall).
REQ-019 LOAD, in_cnt=N-1 with accepted tlast: go to DRAIN.
REQ-020 LOAD, accepted tlast with in_cnt<N-1: set err_short, go to PAD.
REQ-021 PAD: s_axis_tready=0, f_tvalid=1, f_tdata=0 until in_cnt=N-1, then DRAIN.
REQ-022 LOAD, in_cnt=N-1 without tlast: set err_long, go to DISCARD.
REQ-023 DISCARD: s_axis_tready=1, f_tvalid=0, samples dropped until accepted tlast, then DRAIN.
REQ-024 DRAIN: all inputs held off; go to UNLOAD on first f_out_tvalid.
REQ-025 UNLOAD: out_cnt counts f_out_tvalid beats; after beat N-1, increment frames_done, return to IDLE.
REQ-026 Output path SHALL be registered, latency 1 cycle: m_axis_tdata/tvalid/tuser <= f_out_tdata/tvalid/index.
REQ-027 m_axis_tlast SHALL be 1 with output beat out_cnt=N-1, else 0.
REQ-028 Pipeline output cannot stall: m_axis_tvalid & !m_axis_tready SHALL set err_overrun; beat is lost, counting continues.
REQ-029 Sticky flags: set has priority over err_clr in the same cycle.
REQ-030 in_cnt/out_cnt are L_WIDTH bits; terminal compare is all-ones, no wrap reliance.
REQ-031 enable deasserted outside IDLE SHALL NOT abort the current frame.

Reset
REQ-032 ARESET SHALL force IDLE, clear in_cnt, out_cnt, frames_done, all error flags, and all m_axis outputs to 0, in any state.
REQ-033 After mid-frame reset, the next frame SHALL start only after f_tready=1 (pipeline self-flush).

Structure
REQ-034 Shared package holds the FSM state encoding and the error-flag bit positions.
REQ-035 One sub-module, fwht_frame_cnt (L_WIDTH counter with clear, enable, terminal flag), instantiated for in_cnt and out_cnt.

Verification (L_WIDTH=3, N=8)
REQ-036 Frame 1..8, tlast on 8th, m_axis_tready=1 -> 8 output beats, tlast on 8th, frames_done=1, no errors.
REQ-037 Frame of 5 samples with tlast on 5th -> err_short=1, f_tdata=0 for slots 5..7, 8 output beats.
REQ-038 Frame of 10 samples, tlast on 10th -> err_long=1, samples 9..10 absent from f_tvalid, 8 output beats.
REQ-039 m_axis_tready=0 during output beat 3 -> err_overrun=1, tlast still on beat 8; err_clr pulse clears it.
REQ-040 ARESET during LOAD at in_cnt=4 -> IDLE next cycle, all outputs 0, next full frame processed correctly.
REQ-041 Upstream tvalid low for 1 cycle at slot 2 -> f_tdata=0 at slot 2, frame still 8 beats.
